// File: rtl/psum_arb_pkg.sv
// Shared types for the psum GLB arbiter: requester IDs, owner type, FSM states
// and the read-return tag that travels alongside the SRAM read latency.
package psum_arb_pkg;

   typedef logic [1:0] owner_t;

   localparam owner_t REQ_ST = 2'd0;
   localparam owner_t REQ_LD = 2'd1;
   localparam owner_t REQ_DR = 2'd2;

   typedef enum logic {
      ARB   = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic   valid;
      owner_t id;
   } rd_tag_t;

   function automatic owner_t next_owner(input owner_t o);
      return (o == REQ_DR) ? REQ_ST : owner_t'(o + 2'd1);
   endfunction

   function automatic owner_t onehot_to_id(input logic [2:0] oh);
      owner_t id;
      case (oh)
         3'b010:  id = REQ_LD;
         3'b100:  id = REQ_DR;
         default: id = REQ_ST;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin picker: search starts at ptr and wraps st -> ld -> dr.
// Purely combinational; returns a one-hot winner, or zero when nobody requests.
module rr_arb3
   import psum_arb_pkg::*;
(
   input  logic [2:0] req,
   input  owner_t     ptr,
   output logic [2:0] grant
);

   always_comb begin
      grant = 3'b000;
      case (ptr)
         REQ_LD: begin
            if      (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
         end
         REQ_DR: begin
            if      (req[2]) grant = 3'b100;
            else if (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
         end
         default: begin
            if      (req[0]) grant = 3'b001;
            else if (req[1]) grant = 3'b010;
            else if (req[2]) grant = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/psum_glb_arbiter.sv
// Burst arbiter sharing the single-port psum GLB between store, reload and drain.
// Optional macro PSUM_ARB_STATS_EN adds saturating beat/stall counters.
module psum_glb_arbiter
   import psum_arb_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_st_req,
   input  logic              i_st_last,
   input  logic [ADDR_W-1:0] i_st_addr,
   input  logic [DATA_W-1:0] i_st_wdata,
   output logic              o_st_gnt,
   input  logic              i_ld_req,
   input  logic              i_ld_last,
   input  logic [ADDR_W-1:0] i_ld_addr,
   output logic              o_ld_gnt,
   output logic              o_ld_rvalid,
   input  logic              i_dr_req,
   input  logic              i_dr_last,
   input  logic [ADDR_W-1:0] i_dr_addr,
   output logic              o_dr_gnt,
   output logic              o_dr_rvalid,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_glb_en,
   output logic              o_glb_we,
   output logic [ADDR_W-1:0] o_glb_addr,
   output logic [DATA_W-1:0] o_glb_wdata,
   input  logic [DATA_W-1:0] i_glb_rdata,
   output logic              o_busy
`ifdef PSUM_ARB_STATS_EN
   ,
   output logic [31:0]       o_stat_st_beats,
   output logic [31:0]       o_stat_ld_beats,
   output logic [31:0]       o_stat_dr_beats,
   output logic [31:0]       o_stat_stall
`endif
);

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            ptr_q, ptr_d;
   logic [2:0]        req_vec;
   logic [2:0]        win;
   logic [2:0]        owner_mask;
   logic              owner_req;
   logic              owner_last;
   logic [ADDR_W-1:0] owner_addr;
   logic              accept;
   rd_tag_t           cmd_tag;
   rd_tag_t           tag_pipe [READ_LAT];
   rd_tag_t           ret_tag;
   logic              in_flight;

   assign req_vec = {i_dr_req, i_ld_req, i_st_req};

   rr_arb3 u_rr_arb3 (
      .req   (req_vec),
      .ptr   (ptr_q),
      .grant (win)
   );

   always_comb begin
      owner_req  = 1'b0;
      owner_last = 1'b0;
      owner_addr = '0;
      owner_mask = 3'b000;
      case (owner_q)
         REQ_ST: begin
            owner_req  = i_st_req;
            owner_last = i_st_last;
            owner_addr = i_st_addr;
            owner_mask = 3'b001;
         end
         REQ_LD: begin
            owner_req  = i_ld_req;
            owner_last = i_ld_last;
            owner_addr = i_ld_addr;
            owner_mask = 3'b010;
         end
         REQ_DR: begin
            owner_req  = i_dr_req;
            owner_last = i_dr_last;
            owner_addr = i_dr_addr;
            owner_mask = 3'b100;
         end
         default: ;
      endcase
   end

   // Grant is simply the owner's own request while in BURST, so a stalled owner keeps the bank.
   assign accept   = (state_q == BURST) && owner_req;
   assign o_st_gnt = accept && (owner_q == REQ_ST);
   assign o_ld_gnt = accept && (owner_q == REQ_LD);
   assign o_dr_gnt = accept && (owner_q == REQ_DR);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         ARB: begin
            if (|req_vec) begin
               owner_d = onehot_to_id(win);
               state_d = BURST;
            end
         end
         BURST: begin
            if (accept && owner_last) begin
               state_d = ARB;
               ptr_d   = next_owner(owner_q);
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ARB;
         owner_q <= REQ_ST;
         ptr_q   <= REQ_ST;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_glb_en    <= 1'b0;
         o_glb_we    <= 1'b0;
         o_glb_addr  <= '0;
         o_glb_wdata <= '0;
         cmd_tag     <= '0;
      end else begin
         o_glb_en      <= accept;
         o_glb_we      <= accept && (owner_q == REQ_ST);
         cmd_tag.valid <= accept && (owner_q != REQ_ST);
         cmd_tag.id    <= owner_q;
         if (accept) begin
            o_glb_addr <= owner_addr;
         end
         if (accept && (owner_q == REQ_ST)) begin
            o_glb_wdata <= i_st_wdata;
         end
      end
   end

   // The tag rides READ_LAT stages behind the command so it lines up with i_glb_rdata.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < READ_LAT; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= cmd_tag;
         for (int i = 1; i < READ_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   assign ret_tag = tag_pipe[READ_LAT-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ld_rvalid <= 1'b0;
         o_dr_rvalid <= 1'b0;
         o_rdata     <= '0;
      end else begin
         o_ld_rvalid <= ret_tag.valid && (ret_tag.id == REQ_LD);
         o_dr_rvalid <= ret_tag.valid && (ret_tag.id == REQ_DR);
         if (ret_tag.valid) begin
            o_rdata <= i_glb_rdata;
         end
      end
   end

   always_comb begin
      in_flight = cmd_tag.valid;
      for (int i = 0; i < READ_LAT; i++) begin
         in_flight = in_flight | tag_pipe[i].valid;
      end
   end

   assign o_busy = (state_q == BURST) || in_flight;

`ifdef PSUM_ARB_STATS_EN
   logic stall;

   assign stall = (state_q == BURST) && |(req_vec & ~owner_mask);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stat_st_beats <= '0;
         o_stat_ld_beats <= '0;
         o_stat_dr_beats <= '0;
         o_stat_stall    <= '0;
      end else begin
         if (o_st_gnt && (o_stat_st_beats != '1)) o_stat_st_beats <= o_stat_st_beats + 32'd1;
         if (o_ld_gnt && (o_stat_ld_beats != '1)) o_stat_ld_beats <= o_stat_ld_beats + 32'd1;
         if (o_dr_gnt && (o_stat_dr_beats != '1)) o_stat_dr_beats <= o_stat_dr_beats + 32'd1;
         if (stall && (o_stat_stall != '1))       o_stat_stall    <= o_stat_stall + 32'd1;
      end
   end
`endif

endmodule
